// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// performance counter width and the load-use detection helper.
package hazard_pkg;

    localparam int unsigned CntWidth = 16;

    typedef enum logic [1:0] {
        Run     = 2'b00,
        LuStall = 2'b01,
        MemWait = 2'b10
    } hazard_state_e;

    // A load in EX whose non-zero destination feeds a source read by the ID instruction.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd_addr,
        input logic [4:0] rs1_addr,
        input logic [4:0] rs2_addr,
        input logic       uses_rs2
    );
        return mem_read && (rd_addr != 5'd0) &&
               ((rd_addr == rs1_addr) || (uses_rs2 && (rd_addr == rs2_addr)));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating stall-cycle and flush counters for the hazard controller.
// Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counter
    import hazard_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic [CntWidth-1:0] stall_cycles_o,
    output logic [CntWidth-1:0] flush_count_o
);

    logic [CntWidth-1:0] stall_cnt_q;
    logic [CntWidth-1:0] flush_cnt_q;

    // Count stall and flush cycles, holding at all-ones; cleared while in reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_i && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory wait stalls and
// taken-branch flushes for a 5-stage pipeline. Outputs are Mealy.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [4:0]          IFID_RS1addr_i,
    input  logic [4:0]          IFID_RS2addr_i,
    input  logic                IFID_UsesRS2_i,
    input  logic [4:0]          IDEX_RDaddr_i,
    input  logic                IDEX_MemRead_i,
    input  logic                Branch_taken_i,
    input  logic                EXMEM_MemReq_i,
    input  logic                DMem_ready_i,
    output logic                PC_Write_o,
    output logic                IFID_Write_o,
    output logic                IDEX_Write_o,
    output logic                EXMEM_Write_o,
    output logic                IFID_Flush_o,
    output logic                IDEX_Bubble_o,
    output logic                MEMWB_Bubble_o,
    output logic [1:0]          State_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CntWidth-1:0] StallCycles_o,
    output logic [CntWidth-1:0] FlushCount_o
`endif
);

    hazard_state_e state_q, state_d;
    logic lu;
    logic mw;
    logic lu_stall;

    assign lu = load_use(IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
                         IFID_UsesRS2_i);
    assign mw = EXMEM_MemReq_i && !DMem_ready_i;

    // lu only stalls outside LuStall; the MemWait exit cycle behaves like Run.
    assign lu_stall = lu && !mw && (state_q != LuStall);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= Run;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory wait dominates, then a load-use stall, else back to Run.
    always_comb begin
        state_d = Run;
        if (mw) begin
            state_d = MemWait;
        end else if (lu_stall) begin
            state_d = LuStall;
        end
    end

    // Output decode; reset forces every register to hold with NOPs injected.
    always_comb begin
        PC_Write_o     = 1'b1;
        IFID_Write_o   = 1'b1;
        IDEX_Write_o   = 1'b1;
        EXMEM_Write_o  = 1'b1;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b0;
        MEMWB_Bubble_o = 1'b0;
        State_o        = state_q;
        if (!rst_i) begin
            PC_Write_o     = 1'b0;
            IFID_Write_o   = 1'b0;
            IDEX_Write_o   = 1'b0;
            EXMEM_Write_o  = 1'b0;
            IFID_Flush_o   = 1'b1;
            IDEX_Bubble_o  = 1'b1;
            MEMWB_Bubble_o = 1'b1;
            State_o        = Run;
        end else if (mw) begin
            PC_Write_o     = 1'b0;
            IFID_Write_o   = 1'b0;
            IDEX_Write_o   = 1'b0;
            EXMEM_Write_o  = 1'b0;
            MEMWB_Bubble_o = 1'b1;
        end else if (lu_stall) begin
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else begin
            IFID_Flush_o = Branch_taken_i;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter u_perf (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (!PC_Write_o),
        .flush_i        (IFID_Flush_o),
        .stall_cycles_o (StallCycles_o),
        .flush_count_o  (FlushCount_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs2, mem_read, br, mem_req, ready;
    logic       pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_bb, memwb_bb;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // {PC, IFID, IDEX, EXMEM write, IFID flush, IDEX bubble, MEMWB bubble}
    localparam logic [6:0] CRst  = 7'b0000_111;
    localparam logic [6:0] CIdle = 7'b1111_000;
    localparam logic [6:0] CLu   = 7'b0011_010;
    localparam logic [6:0] CMw   = 7'b0000_001;
    localparam logic [6:0] CBr   = 7'b1111_100;

    wire [6:0] ctl = {pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_bb, memwb_bb};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .IFID_RS1addr_i (rs1),
        .IFID_RS2addr_i (rs2),
        .IFID_UsesRS2_i (uses_rs2),
        .IDEX_RDaddr_i  (rd),
        .IDEX_MemRead_i (mem_read),
        .Branch_taken_i (br),
        .EXMEM_MemReq_i (mem_req),
        .DMem_ready_i   (ready),
        .PC_Write_o     (pc_we),
        .IFID_Write_o   (ifid_we),
        .IDEX_Write_o   (idex_we),
        .EXMEM_Write_o  (exmem_we),
        .IFID_Flush_o   (ifid_fl),
        .IDEX_Bubble_o  (idex_bb),
        .MEMWB_Bubble_o (memwb_bb),
        .State_o        (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles_o  (stall_cnt),
        .FlushCount_o   (flush_cnt)
`endif
    );

    // Apply a new input vector just after the falling edge, then let it settle.
    task automatic drive(input logic r, input logic mr, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                         input logic b, input logic mq, input logic rdy);
        @(negedge clk);
        rst = r; mem_read = mr; rd = d; rs1 = s1; rs2 = s2; uses_rs2 = u2;
        br = b; mem_req = mq; ready = rdy;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string tag, input logic [6:0] c_exp, input logic [1:0] s_exp);
        n_assert++;
        assert (ctl === c_exp) else begin
            n_fail++;
            $error("FAIL %s ctl: observed %b expected %b", tag, ctl, c_exp);
        end
        n_assert++;
        assert (state === s_exp) else begin
            n_fail++;
            $error("FAIL %s state: observed %b expected %b", tag, state, s_exp);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic chk_cnt(input string tag, input logic [15:0] s_exp, input logic [15:0] f_exp);
        n_assert++;
        assert (stall_cnt === s_exp) else begin
            n_fail++;
            $error("FAIL %s stall: observed %0d expected %0d", tag, stall_cnt, s_exp);
        end
        n_assert++;
        assert (flush_cnt === f_exp) else begin
            n_fail++;
            $error("FAIL %s flush: observed %0d expected %0d", tag, flush_cnt, f_exp);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; mem_read = 1'b0; rd = '0; rs1 = '0; rs2 = '0; uses_rs2 = 1'b0;
        br = 1'b0; mem_req = 1'b0; ready = 1'b1;

        // Reset
        drive(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst0", CRst, 2'b00);
        drive(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst1", CRst, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk_cnt("cnt_rst", 16'd0, 16'd0);
`endif
        idle();
        chk("idle", CIdle, 2'b00);

        // Load-use on rs1: one stall cycle, lu ignored while in LuStall
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_rs1", CLu, 2'b00);
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_hold", CIdle, 2'b01);
        idle();
        chk("lu_back", CIdle, 2'b00);

        // Suppressed hazards
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rd_zero", CIdle, 2'b00);
        drive(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rs2_unused", CIdle, 2'b00);
        drive(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lu_rs2", CLu, 2'b00);
        idle();
        chk("lu_rs2_hold", CIdle, 2'b01);
        idle();
        chk("lu_rs2_back", CIdle, 2'b00);

        // Memory wait for three cycles
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mw1", CMw, 2'b00);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mw2", CMw, 2'b10);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mw3", CMw, 2'b10);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mw_exit", CIdle, 2'b10);
        idle();
        chk("mw_back", CIdle, 2'b00);

        // Plain taken branch
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("branch", CBr, 2'b00);

        // lu and mw together: mw wins, lu stall follows the MemWait exit
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lumw1", CMw, 2'b00);
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lumw2", CMw, 2'b10);
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lumw_exit", CLu, 2'b10);
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lumw_stall", CIdle, 2'b01);
        idle();
        chk("lumw_back", CIdle, 2'b00);

        // Branch during load-use: no flush in the stall cycle, flush in LuStall
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("br_lu", CLu, 2'b00);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("br_lustall", CBr, 2'b01);
        idle();
        chk("br_back", CIdle, 2'b00);

        // Reset mid-MemWait
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rmw1", CMw, 2'b00);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rmw2", CMw, 2'b10);
        drive(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rmw_rst", CRst, 2'b00);
        idle();
        chk("rmw_after", CIdle, 2'b00);

        // Reset mid-LuStall
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rlu1", CLu, 2'b00);
        drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rlu_rst", CRst, 2'b00);
        idle();
        chk("rlu_after", CIdle, 2'b00);

`ifdef HAZARD_PERF_CNT_EN
        // Counters start from a fresh reset
        drive(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk_cnt("cnt_clr", 16'd0, 16'd0);
        drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk_cnt("cnt_final", 16'd4, 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have ports IFID_RS1addr_i and IFID_RS2addr_i, input, 5 each: source registers of the instruction in ID.
REQ-004 SHALL have port IFID_UsesRS2_i, input, 1: the ID instruction reads rs2.
REQ-005 SHALL have ports IDEX_RDaddr_i (input, 5) and IDEX_MemRead_i (input, 1): destination and load flag of the instruction in EX.
REQ-006 SHALL have port Branch_taken_i, input, 1: branch resolved taken in ID this cycle.
REQ-007 SHALL have ports EXMEM_MemReq_i (input, 1) and DMem_ready_i (input, 1): MEM-stage access pending, and data memory completes it this cycle.
REQ-008 SHALL have outputs PC_Write_o, IFID_Write_o, IDEX_Write_o and EXMEM_Write_o, 1 each: pipeline register load enables.
REQ-009 SHALL have outputs IFID_Flush_o, IDEX_Bubble_o and MEMWB_Bubble_o, 1 each: insert a NOP into the named register.
REQ-010 SHALL have output State_o, output, 2: FSM state, encoded RUN=00, LU_STALL=01, MEM_WAIT=10.

Function
REQ-011 SHALL define a load-use hazard (lu) as: IDEX_MemRead_i && IDEX_RDaddr_i!=0 && (IDEX_RDaddr_i==IFID_RS1addr_i || (IFID_UsesRS2_i && IDEX_RDaddr_i==IFID_RS2addr_i)).
REQ-012 SHALL define a memory wait (mw) as: EXMEM_MemReq_i && !DMem_ready_i.
REQ-013 SHALL compute outputs combinationally from the current state and inputs (Mealy), with zero-cycle latency.
REQ-014 SHALL give mw the highest priority: PC/IFID/IDEX/EXMEM_Write=0, MEMWB_Bubble=1, IFID_Flush=0, IDEX_Bubble=0; next state MEM_WAIT.
REQ-015 SHALL stay in MEM_WAIT while mw=1, and go to RUN in the first cycle mw=0; outputs in that exit cycle follow the RUN rules.
REQ-016 SHALL, in RUN with lu=1 and mw=0, drive PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IDEX/EXMEM_Write=1 and IFID_Flush=0; next state LU_STALL.
REQ-017 SHALL ignore lu in LU_STALL, drive all write enables 1 and go to RUN next cycle; a load-use stall therefore lasts exactly 1 cycle.
REQ-018 SHALL assert IFID_Flush_o when Branch_taken_i=1 and neither mw nor a RUN-state lu stall is active; PC_Write stays 1.
REQ-019 SHALL, otherwise, drive all write enables 1 and all flush/bubble outputs 0.
REQ-020 SHALL, when lu and mw are both 1, apply only the mw behaviour; lu is re-evaluated after MEM_WAIT exits.

Reset
REQ-021 SHALL, while rst_i=0, force: State=RUN; all write enables 0; IFID_Flush, IDEX_Bubble and MEMWB_Bubble 1; counters 0.
REQ-022 SHALL, when rst_i falls mid-stall (LU_STALL or MEM_WAIT), abandon the stall and enter RUN on the next edge.

Configuration
REQ-023 SHALL, when HAZARD_PERF_CNT_EN is defined, add outputs StallCycles_o (16) and FlushCount_o (16).
- StallCycles_o: counts cycles with PC_Write_o=0 outside reset.
- FlushCount_o: counts cycles with IFID_Flush_o=1 outside reset.
- Both saturate at 16'hFFFF.
REQ-024 SHALL, when HAZARD_PERF_CNT_EN is undefined, omit those ports and counters; all other behaviour is identical.

Structure
REQ-025 SHALL take the state encoding constants (RUN, LU_STALL, MEM_WAIT) and the counter width (16) from the shared package hazard_pkg.
REQ-026 SHALL place the counters in sub-module hazard_perf_counter, instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-027 SHALL test load-use: IDEX_MemRead=1, RD=5, RS1=5 -> one cycle PC_Write=0, IDEX_Bubble=1, State 00->01->00.
REQ-028 SHALL test suppressed hazards:
- RD=0 with RS1=0 and MemRead=1 -> no stall.
- RD=7, RS2=7, UsesRS2=0 -> no stall.
REQ-029 SHALL test a memory wait: MemReq=1, ready=0 for 3 cycles -> 3 cycles with all write enables 0 and MEMWB_Bubble=1, State=10; RUN on the 4th.
REQ-030 SHALL test simultaneous events:
- lu and mw together -> mw behaviour only; lu stall follows MEM_WAIT exit.
- Branch_taken during lu -> no flush that cycle.
REQ-031 SHALL test reset mid-MEM_WAIT: rst_i=0 for 1 cycle -> reset values, then State=00.
REQ-032 SHALL test, with HAZARD_PERF_CNT_EN defined, a load-use stall and a MEM_WAIT of 3 cycles -> StallCycles_o=4; and 2 taken branches -> FlushCount_o=2.
